// File: rtl/seq_divider_pkg.sv
// Shared MDU op codes and op-decoding helpers for the sequential divider.
package seq_divider_pkg;

  localparam logic [1:0] MDU_DIV  = 2'b00;
  localparam logic [1:0] MDU_DIVU = 2'b01;
  localparam logic [1:0] MDU_REM  = 2'b10;
  localparam logic [1:0] MDU_REMU = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/seq_divider_sign_fix.sv
// Operand magnitude extraction on entry and quotient/remainder sign
// correction on exit; purely combinational.
module seq_divider_sign_fix
  import seq_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      entry_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] abs_a,
  output logic [XLEN-1:0] abs_b,
  output logic            a_neg,
  output logic            b_neg,
  input  logic [1:0]      fix_op,
  input  logic            fix_a_neg,
  input  logic            fix_b_neg,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] rem,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

  // Magnitudes of the incoming operands; unsigned ops pass through.
  always_comb begin
    a_neg = op_is_signed(entry_op) & a[XLEN-1];
    b_neg = op_is_signed(entry_op) & b[XLEN-1];
    abs_a = a_neg ? (ZERO - a) : a;
    abs_b = b_neg ? (ZERO - b) : b;
  end

  // Quotient takes the xor of the signs, remainder follows the dividend.
  always_comb begin
    result = quo;
    case (fix_op)
      MDU_DIV: begin
        if (fix_a_neg ^ fix_b_neg) result = ZERO - quo;
        else                       result = quo;
      end
      MDU_DIVU: result = quo;
      MDU_REM: begin
        if (fix_a_neg) result = ZERO - rem;
        else           result = rem;
      end
      MDU_REMU: result = rem;
      default:  result = quo;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// RV32M multi-cycle divide unit: restoring shift-subtract, one quotient bit
// per cycle, with single-cycle bypass for divide-by-zero and signed overflow.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   rem_r, quo_r, div_r, result_r;
  logic [1:0]        op_r;
  logic              a_neg_r, b_neg_r, busy_r, valid_r;

  logic              accept_s, special_s;
  logic [XLEN-1:0]   special_res_s, abs_a_s, abs_b_s, fixed_s;
  logic              a_neg_s, b_neg_s;
  logic [XLEN:0]     shift_s, trial_s;

  seq_divider_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .entry_op  (op_i),
    .a         (a_i),
    .b         (b_i),
    .abs_a     (abs_a_s),
    .abs_b     (abs_b_s),
    .a_neg     (a_neg_s),
    .b_neg     (b_neg_s),
    .fix_op    (op_r),
    .fix_a_neg (a_neg_r),
    .fix_b_neg (b_neg_r),
    .quo       (quo_r),
    .rem       (rem_r),
    .result    (fixed_s)
  );

  assign accept_s = (state_r == S_IDLE) & start_i & ~flush_i;

  // Divide-by-zero and signed-overflow results that skip iteration.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = ZERO;
    if (b_i == ZERO) begin
      special_s     = 1'b1;
      special_res_s = op_is_rem(op_i) ? a_i : ONES;
    end else if (op_is_signed(op_i) && (a_i == MIN_NEG) && (b_i == ONES)) begin
      special_s     = 1'b1;
      special_res_s = op_is_rem(op_i) ? ZERO : MIN_NEG;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO;
    end
  end

  // One restoring step: the extra top bit of the trial result is the borrow.
  always_comb begin
    shift_s = {rem_r, quo_r[XLEN-1]};
    trial_s = shift_s - {1'b0, div_r};
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = special_s ? S_DONE : S_RUN;
        else          state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (flush_i)                state_nxt_s = S_IDLE;
        else if (cnt_r == CNT_LAST) state_nxt_s = S_FIX;
        else                        state_nxt_s = S_RUN;
      end
      S_FIX: begin
        if (flush_i) state_nxt_s = S_IDLE;
        else         state_nxt_s = S_DONE;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= S_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= ZERO;
      quo_r    <= ZERO;
      div_r    <= ZERO;
      result_r <= ZERO;
      op_r     <= 2'b00;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s != S_IDLE);
      valid_r <= (state_nxt_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= op_i;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            quo_r   <= abs_a_s;
            div_r   <= abs_b_s;
            rem_r   <= ZERO;
            cnt_r   <= {CNT_W{1'b0}};
            if (special_s) result_r <= special_res_s;
          end
        end
        S_RUN: begin
          if (!flush_i) begin
            cnt_r <= cnt_r + CNT_ONE;
            quo_r <= {quo_r[XLEN-2:0], ~trial_s[XLEN]};
            rem_r <= trial_s[XLEN] ? shift_s[XLEN-1:0] : trial_s[XLEN-1:0];
          end
        end
        S_FIX: begin
          if (!flush_i) result_r <= fixed_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o   = busy_r;
  assign valid_o  = valid_r;
  assign result_o = result_r;

endmodule
